// File: rtl/nonce_search_ctrl_if.sv
// rtl/nonce_search_ctrl_if.sv - host, hash-unit and result signals of the nonce search controller
//
// Purpose: bundles every non-clock signal of nonce_search_ctrl.
// Ports (signals):
//   start_i, base_nonce_i, difficulty_i, max_attempts_i  search request, latched on start
//   abort_i, result_ack_i                                  cancel / result acknowledge
//   hash_nonce_o, hash_valid_o, hash_digest_i              combinational hash unit link
//   busy_o, done_o, found_o, result_nonce_o,
//   result_digest_o, attempts_o                            search status and result
// Modports: slave = the controller, master = host plus hash unit.
interface nonce_search_ctrl_if #(
  parameter int CNT_W  = 32,
  parameter int DIFF_W = 9
);
  logic              start_i;
  logic [255:0]      base_nonce_i;
  logic [DIFF_W-1:0] difficulty_i;
  logic [CNT_W-1:0]  max_attempts_i;
  logic              abort_i;
  logic              result_ack_i;
  logic [255:0]      hash_nonce_o;
  logic              hash_valid_o;
  logic [255:0]      hash_digest_i;
  logic              busy_o;
  logic              done_o;
  logic              found_o;
  logic [255:0]      result_nonce_o;
  logic [255:0]      result_digest_o;
  logic [CNT_W-1:0]  attempts_o;

  modport slave (
    input  start_i, base_nonce_i, difficulty_i, max_attempts_i, abort_i, result_ack_i,
    input  hash_digest_i,
    output hash_nonce_o, hash_valid_o, busy_o, done_o, found_o,
    output result_nonce_o, result_digest_o, attempts_o
  );

  modport master (
    output start_i, base_nonce_i, difficulty_i, max_attempts_i, abort_i, result_ack_i,
    output hash_digest_i,
    input  hash_nonce_o, hash_valid_o, busy_o, done_o, found_o,
    input  result_nonce_o, result_digest_o, attempts_o
  );
endinterface

// File: rtl/nonce_search_ctrl.sv
// rtl/nonce_search_ctrl.sv - sequential nonce issuer and leading-zero difficulty checker
//
// Purpose: issues base, base+1, ... to a combinational SHA-256 unit, one per clock,
// registers each nonce/digest pair and reports the first digest meeting the
// leading-zero target (or budget exhaustion) through done/ack.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nonce_search_ctrl_if.slave (request, hash link, result)
module nonce_search_ctrl #(
  parameter int CNT_W  = 32,
  parameter int DIFF_W = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nonce_search_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_t;

  state_t           state;
  logic [255:0]     base_q;
  logic [8:0]       diff_q;
  logic [CNT_W-1:0] budget_q;
  logic [CNT_W-1:0] issue_cnt;
  logic             issue_q;
  logic [255:0]     nonce_q;
  logic [255:0]     digest_q;
  logic             v1;

  logic [31:0]      diff_ext;
  logic [8:0]       diff_clamped;
  logic [255:0]     zero_mask;
  logic             hit;
  logic [255:0]     nonce_off;
  logic [CNT_W-1:0] hit_attempts;

  always_comb begin
    diff_ext     = 32'(bus.difficulty_i);
    diff_clamped = (diff_ext > 32'd256) ? 9'd256 : diff_ext[8:0];
    // Ones over the top diff_q bits; a shift by 256 leaves a full mask.
    zero_mask    = ~({256{1'b1}} >> diff_q);
    hit          = v1 && ((digest_q & zero_mask) == '0);
    nonce_off    = nonce_q - base_q;
    hit_attempts = nonce_off[CNT_W-1:0] + CNT_W'(1);
  end

  // A hit found this cycle suppresses the candidate currently on the bus, so
  // nothing past the winner is ever presented as live.
  assign bus.hash_valid_o = issue_q & ~hit;
  assign bus.busy_o       = (state == SEARCH) || (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      base_q              <= '0;
      diff_q              <= '0;
      budget_q            <= '0;
      issue_cnt           <= '0;
      issue_q             <= 1'b0;
      nonce_q             <= '0;
      digest_q            <= '0;
      v1                  <= 1'b0;
      bus.hash_nonce_o    <= '0;
      bus.done_o          <= 1'b0;
      bus.found_o         <= 1'b0;
      bus.result_nonce_o  <= '0;
      bus.result_digest_o <= '0;
      bus.attempts_o      <= '0;
    end else begin
      nonce_q  <= bus.hash_nonce_o;
      digest_q <= bus.hash_digest_i;
      v1       <= bus.hash_valid_o;

      if (bus.abort_i) begin
        state               <= IDLE;
        issue_q             <= 1'b0;
        v1                  <= 1'b0;
        bus.hash_nonce_o    <= '0;
        bus.done_o          <= 1'b0;
        bus.found_o         <= 1'b0;
        bus.result_nonce_o  <= '0;
        bus.result_digest_o <= '0;
        bus.attempts_o      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_i) begin
              base_q              <= bus.base_nonce_i;
              diff_q              <= diff_clamped;
              budget_q            <= bus.max_attempts_i;
              issue_cnt           <= '0;
              bus.attempts_o      <= '0;
              bus.found_o         <= 1'b0;
              bus.result_nonce_o  <= '0;
              bus.result_digest_o <= '0;
              if (bus.max_attempts_i == '0) begin
                state      <= DONE;
                bus.done_o <= 1'b1;
              end else begin
                state            <= SEARCH;
                issue_q          <= 1'b1;
                bus.hash_nonce_o <= bus.base_nonce_i;
              end
            end
          end

          SEARCH, DRAIN: begin
            if (hit) begin
              state               <= DONE;
              issue_q             <= 1'b0;
              v1                  <= 1'b0;
              bus.done_o          <= 1'b1;
              bus.found_o         <= 1'b1;
              bus.result_nonce_o  <= nonce_q;
              bus.result_digest_o <= digest_q;
              bus.attempts_o      <= hit_attempts;
            end else if (state == SEARCH) begin
              issue_cnt <= issue_cnt + CNT_W'(1);
              if (issue_cnt + CNT_W'(1) == budget_q) begin
                state   <= DRAIN;
                issue_q <= 1'b0;
              end else begin
                bus.hash_nonce_o <= bus.hash_nonce_o + 256'd1;
              end
            end else if (!v1) begin
              // Last candidate has left stage 1 without hitting.
              state          <= DONE;
              bus.done_o     <= 1'b1;
              bus.found_o    <= 1'b0;
              bus.attempts_o <= budget_q;
            end
          end

          DONE: begin
            if (bus.result_ack_i) begin
              state       <= IDLE;
              bus.done_o  <= 1'b0;
              bus.found_o <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// tb/tb_nonce_search_ctrl.sv - scoreboard bench for nonce_search_ctrl
module tb_nonce_search_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nonce_search_ctrl_if #(.CNT_W(32), .DIFF_W(9)) bus ();

  nonce_search_ctrl #(.CNT_W(32), .DIFF_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         found;
    logic [255:0] nonce;
    logic [255:0] digest;
    int           attempts;
    int           issues;
    int           done_cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           run_id = 0;
  int           mode = 0;
  logic [255:0] hit_nonce = '0;
  logic [255:0] run_base = '0;

  // mode 0: all-ones except an all-zero digest for hit_nonce; mode 1: mixed value.
  function automatic logic [255:0] model_hash(input logic [255:0] n, input int m,
                                              input logic [255:0] hn);
    logic [31:0] x;
    if (m == 0) return (n == hn) ? 256'd0 : {256{1'b1}};
    x = n[31:0] * 32'h9E37_79B1 + n[63:32];
    x = x ^ (x >> 15);
    x = x * 32'h85EB_CA6B;
    return {8{x}};
  endfunction

  function automatic int lead_zeros(input logic [255:0] d);
    for (int i = 255; i >= 0; i--) if (d[i]) return 255 - i;
    return 256;
  endfunction

  assign bus.hash_digest_i = model_hash(bus.hash_nonce_o, mode, hit_nonce);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: checks issue order, and pops/compares the scoreboard on done.
  exp_t cur;
  logic prev_done = 1'b0;
  int   seen_id = 0;
  int   issue_idx = 0;
  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id   = run_id;
      issue_idx = 0;
    end
    if (bus.hash_valid_o === 1'b1) begin
      chk("issue_nonce", bus.hash_nonce_o, run_base + 256'(issue_idx));
      issue_idx++;
    end
    if (bus.done_o === 1'b1 && !prev_done) begin
      if (sb_q.size() == 0) begin
        chk("done_without_expect", bus.done_o, 1'b0);
      end else begin
        cur = sb_q.pop_front();
        chk("found", bus.found_o, cur.found);
        chk("result_nonce", bus.result_nonce_o, cur.nonce);
        chk("result_digest", bus.result_digest_o, cur.digest);
        chk("attempts", bus.attempts_o, 256'(cur.attempts));
        chk("issue_count", 256'(issue_idx), 256'(cur.issues));
        chk("busy_in_done", bus.busy_o, 1'b0);
        if (cur.done_cyc >= 0) chk("done_latency", 256'(cyc), 256'(cur.done_cyc));
      end
    end else if (bus.done_o === 1'b1) begin
      chk("held_found", bus.found_o, cur.found);
      chk("held_nonce", bus.result_nonce_o, cur.nonce);
      chk("held_attempts", bus.attempts_o, 256'(cur.attempts));
    end
    prev_done = bus.done_o;
  end

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, bus.busy_o, 1'b0);
    chk({tag, "_done"}, bus.done_o, 1'b0);
    chk({tag, "_found"}, bus.found_o, 1'b0);
    chk({tag, "_valid"}, bus.hash_valid_o, 1'b0);
    chk({tag, "_nonce"}, bus.hash_nonce_o, 256'd0);
    chk({tag, "_rnonce"}, bus.result_nonce_o, 256'd0);
    chk({tag, "_rdigest"}, bus.result_digest_o, 256'd0);
    chk({tag, "_attempts"}, bus.attempts_o, 256'd0);
  endtask

  task automatic issue_start(input logic [255:0] b, input int d, input int bud);
    bus.start_i        = 1'b1;
    bus.base_nonce_i   = b;
    bus.difficulty_i   = 9'(d);
    bus.max_attempts_i = 32'(bud);
    run_base           = b;
    run_id++;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic run(input logic [255:0] b, input int d, input int bud, input int m,
                     input logic [255:0] hn, input int ackd);
    exp_t         e;
    int           dc;
    logic [255:0] dg;
    bit           got;
    mode      = m;
    hit_nonce = hn;
    dc = (d > 256) ? 256 : d;
    e.found = 1'b0; e.nonce = '0; e.digest = '0;
    e.attempts = bud; e.issues = bud; e.done_cyc = -1;
    for (int k = 0; k < bud; k++) begin
      dg = model_hash(b + 256'(k), m, hn);
      if (lead_zeros(dg) >= dc) begin
        e.found = 1'b1; e.nonce = b + 256'(k); e.digest = dg;
        e.attempts = k + 1; e.issues = k + 1;
        break;
      end
    end
    @(negedge clk);
    // First nonce appears in cycle cyc+1; candidate k is done two cycles after its issue.
    if (e.found) e.done_cyc = cyc + 1 + e.attempts + 1;
    else if (bud == 0) e.done_cyc = cyc + 1;
    sb_q.push_back(e);
    issue_start(b, d, bud);
    got = 1'b0;
    for (int i = 0; i < bud + 50; i++) begin
      if (bus.done_o === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) chk("done_timeout", bus.done_o, 1'b1);
    repeat (ackd) @(negedge clk);
    bus.result_ack_i = 1'b1;
    @(negedge clk);
    bus.result_ack_i = 1'b0;
    chk("ack_done_clear", bus.done_o, 1'b0);
    chk("ack_found_clear", bus.found_o, 1'b0);
    chk("ack_busy", bus.busy_o, 1'b0);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.base_nonce_i = '0; bus.difficulty_i = '0;
    bus.max_attempts_i = '0; bus.abort_i = 1'b0; bus.result_ack_i = 1'b0;
    #1;
    check_idle("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(256'h10, 8, 100, 0, 256'h15, 10);
    run(256'h10, 8, 4, 0, 256'h15, 2);
    run(256'h1234, 0, 10, 1, '0, 1);
    run(256'h77, 5, 0, 0, 256'h77, 3);
    run({256{1'b1}}, 8, 10, 0, 256'h1, 1);
    run(256'h40, 8, 4, 0, 256'h43, 0);
    run(256'h40, 8, 4, 0, 256'h42, 0);
    run(256'h90, 300, 8, 0, 256'h92, 1);
    run(256'h90, 256, 8, 1, '0, 1);

    // Abort mid-search: IDLE with cleared outputs on the next cycle, no done.
    mode = 0; hit_nonce = 256'h1000;
    issue_start(256'h500, 8, 100);
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", bus.busy_o, 1'b1);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    check_idle("abort");
    repeat (5) @(negedge clk);
    chk("abort_no_done", bus.done_o, 1'b0);
    run(256'h500, 8, 20, 0, 256'h503, 2);

    // Asynchronous reset mid-search.
    issue_start(256'h600, 8, 100);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_no_done", bus.done_o, 1'b0);
    run(256'h600, 8, 20, 0, 256'h60a, 1);

    for (int r = 0; r < 10; r++) begin
      run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
          int'($urandom_range(0, 5)), int'($urandom_range(1, 40)), 1, '0,
          int'($urandom_range(0, 4)));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 256'(sb_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
